// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard decoder: frame geometry, prefix
// codes and the scan codes of the hex-digit keys.
package ps2_kbd_pkg;

  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned SHIFT_W   = FRAME_LEN - 1;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  // Set-2 make codes of the keys that map to a hex nibble
  localparam logic [7:0] SC_HEX_0 = 8'h45;
  localparam logic [7:0] SC_HEX_1 = 8'h16;
  localparam logic [7:0] SC_HEX_2 = 8'h1E;
  localparam logic [7:0] SC_HEX_3 = 8'h26;
  localparam logic [7:0] SC_HEX_4 = 8'h25;
  localparam logic [7:0] SC_HEX_5 = 8'h2E;
  localparam logic [7:0] SC_HEX_6 = 8'h36;
  localparam logic [7:0] SC_HEX_7 = 8'h3D;
  localparam logic [7:0] SC_HEX_8 = 8'h3E;
  localparam logic [7:0] SC_HEX_9 = 8'h46;
  localparam logic [7:0] SC_HEX_A = 8'h1C;
  localparam logic [7:0] SC_HEX_B = 8'h32;
  localparam logic [7:0] SC_HEX_C = 8'h21;
  localparam logic [7:0] SC_HEX_D = 8'h23;
  localparam logic [7:0] SC_HEX_E = 8'h24;
  localparam logic [7:0] SC_HEX_F = 8'h2B;

endpackage

// File: rtl/ps2_scan_to_hex.sv
// Combinational lookup from a scan code to its hex-digit value; hit is low
// for every code that is not one of the sixteen hex keys.
module ps2_scan_to_hex
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (code)
      SC_HEX_0: nibble = 4'h0;
      SC_HEX_1: nibble = 4'h1;
      SC_HEX_2: nibble = 4'h2;
      SC_HEX_3: nibble = 4'h3;
      SC_HEX_4: nibble = 4'h4;
      SC_HEX_5: nibble = 4'h5;
      SC_HEX_6: nibble = 4'h6;
      SC_HEX_7: nibble = 4'h7;
      SC_HEX_8: nibble = 4'h8;
      SC_HEX_9: nibble = 4'h9;
      SC_HEX_A: nibble = 4'hA;
      SC_HEX_B: nibble = 4'hB;
      SC_HEX_C: nibble = 4'hC;
      SC_HEX_D: nibble = 4'hD;
      SC_HEX_E: nibble = 4'hE;
      SC_HEX_F: nibble = 4'hF;
      default:  hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: synchronises kbdclk/kbddat, assembles and checks
// 11-bit frames, tracks F0/E0 prefixes and maps hex keys to a nibble.
// Define PS2_TIMEOUT_EN to discard partial frames after TIMEOUT_CYCLES idle clocks.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
`ifdef PS2_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       kbdclk,
  input  logic       kbddat,
  output logic [7:0] decoded,
  output logic       code_valid,
  output logic       brk,
  output logic       ext,
  output logic [3:0] kbout,
  output logic       kbout_valid,
  output logic       frame_err
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_LEN - 1);

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned   IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  logic [IDLE_W-1:0] idle_cnt;
`endif

  logic                 kbdclk_meta, kbdclk_s, kbdclk_prev;
  logic                 kbddat_meta, kbddat_s;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [SHIFT_W-1:0]   shreg;
  logic                 brk_pend, ext_pend;

  logic                 fall_c;
  logic                 frame_ok_c;
  logic [7:0]           rx_byte_c;
  logic                 hex_hit_c;
  logic [3:0]           hex_nib_c;

  // shreg holds start, d0..d7, parity (LSB first); stop is the bit on the wire now
  assign fall_c     = kbdclk_prev & ~kbdclk_s;
  assign rx_byte_c  = shreg[8:1];
  assign frame_ok_c = ~shreg[0] & kbddat_s & (^shreg[9:1]);

  ps2_scan_to_hex u_hex (
    .code   (rx_byte_c),
    .hit    (hex_hit_c),
    .nibble (hex_nib_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      kbdclk_meta <= 1'b1;
      kbdclk_s    <= 1'b1;
      kbdclk_prev <= 1'b1;
      kbddat_meta <= 1'b1;
      kbddat_s    <= 1'b1;
      bit_cnt     <= '0;
      shreg       <= '0;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
      decoded     <= 8'h00;
      brk         <= 1'b0;
      ext         <= 1'b0;
      kbout       <= 4'h0;
      code_valid  <= 1'b0;
      kbout_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      kbdclk_meta <= kbdclk;
      kbdclk_s    <= kbdclk_meta;
      kbdclk_prev <= kbdclk_s;
      kbddat_meta <= kbddat;
      kbddat_s    <= kbddat_meta;
      code_valid  <= 1'b0;
      kbout_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (fall_c) begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          shreg   <= '0;
          if (!frame_ok_c) begin
            frame_err <= 1'b1;
          end else if (rx_byte_c == SC_BREAK) begin
            brk_pend <= 1'b1;
          end else if (rx_byte_c == SC_EXT) begin
            ext_pend <= 1'b1;
          end else begin
            decoded    <= rx_byte_c;
            brk        <= brk_pend;
            ext        <= ext_pend;
            code_valid <= 1'b1;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            // only plain makes update the hex value
            if (hex_hit_c && !brk_pend && !ext_pend) begin
              kbout       <= hex_nib_c;
              kbout_valid <= 1'b1;
            end
          end
        end else begin
          shreg   <= {kbddat_s, shreg[SHIFT_W-1:1]};
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
      end

`ifdef PS2_TIMEOUT_EN
      // idle watchdog only runs while a frame is partially received
      if (fall_c || bit_cnt == '0) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IDLE_MAX) begin
        idle_cnt  <= '0;
        bit_cnt   <= '0;
        shreg     <= '0;
        frame_err <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: drives PS/2 frames and checks outputs
// and pulse counts with immediate assertions.
module tb_ps2_kbd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbdclk = 1'b1;
  logic       kbddat = 1'b1;
  logic [7:0] decoded;
  logic       code_valid, brk, ext, kbout_valid, frame_err;
  logic [3:0] kbout;

  int checks = 0;
  int errors = 0;

  int cv_cnt = 0, kv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int cv_base, kv_base, fe_base, both_base;

  always #5 clk = ~clk;

`ifdef PS2_TIMEOUT_EN
  ps2_kbd_decoder #(.TIMEOUT_CYCLES(200)) dut (
`else
  ps2_kbd_decoder dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .kbdclk      (kbdclk),
    .kbddat      (kbddat),
    .decoded     (decoded),
    .code_valid  (code_valid),
    .brk         (brk),
    .ext         (ext),
    .kbout       (kbout),
    .kbout_valid (kbout_valid),
    .frame_err   (frame_err)
  );

  // count output pulses away from the active edge
  always @(negedge clk) begin
    if (code_valid === 1'b1) cv_cnt++;
    if (kbout_valid === 1'b1) kv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (code_valid === 1'b1 && kbout_valid === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic mark();
    cv_base = cv_cnt;
    kv_base = kv_cnt;
    fe_base = fe_cnt;
    both_base = both_cnt;
  endtask

  // bits are sent LSB first, 8 system clocks per kbdclk half-period
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      kbddat = bits[i];
      repeat (8) @(negedge clk);
      kbdclk = 1'b0;
      repeat (8) @(negedge clk);
      kbdclk = 1'b1;
    end
    @(negedge clk);
    kbddat = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  function automatic logic [10:0] frm(input logic [7:0] b, input logic stop);
    return {stop, ~^b, b, 1'b0};
  endfunction

  logic [10:0] aa_bits;
  logic [10:0] a2_bits;

  initial begin
    aa_bits = 11'b111_0101_0100;
    a2_bits = 11'b111_0100_0100;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_decoded", 32'(decoded), 32'h00);
    check("rst_flags", {29'd0, brk, ext, code_valid}, 32'h0);
    check("rst_kbout", 32'(kbout), 32'h0);
    check("rst_pulses", {30'd0, kbout_valid, frame_err}, 32'h0);

    // BAT code: ordinary code, no hex hit
    mark();
    send_bits(aa_bits, 11);
    check("aa_cv", 32'(cv_cnt - cv_base), 32'd1);
    check("aa_kv", 32'(kv_cnt - kv_base), 32'd0);
    check("aa_decoded", 32'(decoded), 32'hAA);
    check("aa_brk", 32'(brk), 32'h0);

    // break prefix then F key: release, no hex update
    mark();
    send_bits(frm(8'hF0, 1'b1), 11);
    check("f0_no_pulse", 32'(cv_cnt - cv_base + fe_cnt - fe_base), 32'd0);
    send_bits(frm(8'h2B, 1'b1), 11);
    check("brk2b_decoded", 32'(decoded), 32'h2B);
    check("brk2b_brk", 32'(brk), 32'h1);
    check("brk2b_kbout", 32'(kbout), 32'h0);
    check("brk2b_kv", 32'(kv_cnt - kv_base), 32'd0);

    // F key make
    mark();
    send_bits(frm(8'h2B, 1'b1), 11);
    check("mk2b_decoded", 32'(decoded), 32'h2B);
    check("mk2b_brk", 32'(brk), 32'h0);
    check("mk2b_kbout", 32'(kbout), 32'hF);
    check("mk2b_together", 32'(both_cnt - both_base), 32'd1);

    // bad parity rejected, then key 0
    mark();
    send_bits(a2_bits, 11);
    check("par_fe", 32'(fe_cnt - fe_base), 32'd1);
    check("par_cv", 32'(cv_cnt - cv_base), 32'd0);
    check("par_decoded", 32'(decoded), 32'h2B);
    send_bits(frm(8'h45, 1'b1), 11);
    check("k45_kbout", 32'(kbout), 32'h0);
    check("k45_kv", 32'(kv_cnt - kv_base), 32'd1);

    // extended prefix: no hex even though code is ordinary
    mark();
    send_bits(frm(8'hE0, 1'b1), 11);
    send_bits(frm(8'h5A, 1'b1), 11);
    check("e05a_decoded", 32'(decoded), 32'h5A);
    check("e05a_flags", {30'd0, brk, ext}, 32'h1);
    check("e05a_kv", 32'(kv_cnt - kv_base), 32'd0);

    // bad stop bit
    mark();
    send_bits(frm(8'h16, 1'b0), 11);
    check("stop_fe", 32'(fe_cnt - fe_base), 32'd1);
    check("stop_decoded", 32'(decoded), 32'h5A);

    // rejected frame keeps the pending break prefix
    mark();
    send_bits(frm(8'hF0, 1'b1), 11);
    send_bits(a2_bits, 11);
    send_bits(frm(8'h1E, 1'b1), 11);
    check("keep_pend_brk", 32'(brk), 32'h1);
    check("keep_pend_kbout", 32'(kbout), 32'h0);
    check("keep_pend_cv", 32'(cv_cnt - cv_base), 32'd1);

    // typematic repeat of key 2
    mark();
    send_bits(frm(8'h1E, 1'b1), 11);
    send_bits(frm(8'h1E, 1'b1), 11);
    check("typematic_cv", 32'(cv_cnt - cv_base), 32'd2);
    check("typematic_kv", 32'(kv_cnt - kv_base), 32'd2);
    check("typematic_kbout", 32'(kbout), 32'h2);

`ifdef PS2_TIMEOUT_EN
    // partial frame abandoned by the idle watchdog
    mark();
    send_bits(frm(8'h16, 1'b1), 5);
    repeat (300) @(negedge clk);
    check("to_fe", 32'(fe_cnt - fe_base), 32'd1);
    send_bits(frm(8'h16, 1'b1), 11);
    check("to_kbout", 32'(kbout), 32'h1);
    check("to_decoded", 32'(decoded), 32'h16);
`endif

    // reset in the middle of a frame
    send_bits(frm(8'h24, 1'b1), 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_decoded", 32'(decoded), 32'h00);
    check("midrst_outs", {25'd0, brk, ext, kbout, code_valid}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    mark();
    send_bits(frm(8'h16, 1'b1), 11);
    check("postrst_decoded", 32'(decoded), 32'h16);
    check("postrst_kbout", 32'(kbout), 32'h1);
    check("postrst_fe", 32'(fe_cnt - fe_base), 32'd0);

    // idle bus: nothing happens
    mark();
    repeat (100) @(negedge clk);
    check("idle_quiet", 32'(cv_cnt - cv_base + fe_cnt - fe_base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
